risc_fetch_unit: RTL and testbench
==================================

Name: risc_fetch_unit

Overview:
Instruction-fetch stage of the RISC CPU, directly upstream of the instruction memory and the decode stage.
- Holds the program counter.
- Drives the word address into the combinational instruction memory.
- Captures the returned instruction into the IF/ID pipeline register.
- Supports decode back-pressure, plus branch/jump redirect with bubble insertion.

Parameters:
RESET_PC, 32'h0000_0000, byte address fetched first after reset (bits [1:0] must be 0)
NOP_INSTR, 32'h0000_0013, bubble encoding (ADDI x0,x0,0) loaded on reset and redirect

Ports:
clk  input  1  rising-edge clock, sole clock domain
rst_n  input  1  asynchronous, active-low reset
imem_address  output  30  word address to instruction memory = pc[31:2]
imem_data  input  32  instruction returned combinationally for imem_address
id_ready  input  1  decode can accept IF/ID contents this cycle
redirect_valid  input  1  taken branch/jump; overrides everything
redirect_pc  input  32  byte target of redirect
if_id_valid  output  1  IF/ID holds a real instruction
if_id_instr  output  32  fetched instruction
if_id_pc  output  32  byte address of if_id_instr
if_id_pc_plus4  output  32  if_id_pc + 4, mod 2^32
misalign_err  output  1  one-cycle pulse: redirect_pc[1:0] != 0
fetch_count  output  32  number of instructions delivered into IF/ID, wraps

Behaviour:
- Reset (asynchronous, takes effect without a clock edge):
  - pc = RESET_PC
  - if_id_valid = 0, if_id_instr = NOP_INSTR
  - if_id_pc = 0, if_id_pc_plus4 = 0
  - misalign_err = 0, fetch_count = 0
- imem_address is purely combinational from the pc register. No other combinational path to outputs.
- advance = !if_id_valid || id_ready. An empty IF/ID always fills.
- Priority at each rising edge: redirect_valid > advance > hold.
- Redirect:
  - pc <= {redirect_pc[31:2], 2'b00}
  - if_id_valid <= 0, if_id_instr <= NOP_INSTR; if_id_pc and if_id_pc_plus4 hold
  - misalign_err <= |redirect_pc[1:0]
  - fetch_count unchanged
  - The instruction held in IF/ID is discarded even when id_ready = 0 (flush beats stall).
  - The instruction on imem_data this cycle is discarded.
- Advance (no redirect):
  - if_id_instr <= imem_data, if_id_pc <= pc, if_id_pc_plus4 <= pc + 4, if_id_valid <= 1
  - pc <= pc + 4 (32-bit wrap: 0xFFFF_FFFC -> 0x0000_0000)
  - fetch_count <= fetch_count + 1, wrapping
  - misalign_err <= 0
- Hold (if_id_valid = 1, id_ready = 0, no redirect):
  - pc and all IF/ID outputs unchanged
  - misalign_err <= 0
- Latency: an instruction appears in IF/ID one edge after its PC is presented.
  - First valid instruction: first edge after rst_n deasserts.
  - Target of a redirect: valid two edges after redirect_valid is sampled (one bubble cycle).
- Consecutive redirects: each one restarts the target; only the last sampled one matters.
- if_id_valid = 0 with id_ready = 0 still fills (bubbles never block the pipe).

Decomposition:
- Shared package risc_pkg:
  - XLEN = 32, NOP_INSTR constant, default RESET_PC
  - typedef struct if_id_t {valid, instr, pc, pc_plus4}
- One sub-module, risc_if_id_reg: IF/ID register with load/flush/hold controls and async active-low reset, reusable for later pipeline registers.
- PC, counter and priority logic stay in risc_fetch_unit.

Test Plan:
1. Reset/straight-line: rst_n low 3 cycles, then high; id_ready = 1; imem model returns 0x0080_0093 at word 0.
   - imem_address steps 0, 1, 2, …
   - Edge 1: if_id_valid = 1, if_id_pc = 0x0, if_id_instr = 0x0080_0093, if_id_pc_plus4 = 0x4.
   - fetch_count = 3 after 3 edges.
2. Stall: id_ready = 0 for 3 cycles while if_id_pc = 0x8.
   - IF/ID outputs, imem_address = 3 and fetch_count all hold.
   - On id_ready = 1, next edge if_id_pc = 0xC.
3. Redirect under stall: id_ready = 0, redirect_valid = 1, redirect_pc = 0x40.
   - Next edge: if_id_valid = 0, if_id_instr = 0x0000_0013, imem_address = 0x10.
   - Following edge: if_id_pc = 0x40, if_id_valid = 1.
4. Misaligned redirect: redirect_pc = 0x42.
   - pc becomes 0x40 (imem_address = 0x10).
   - misalign_err high for exactly one cycle.
5. Wrap: redirect_pc = 0xFFFF_FFFC, id_ready = 1.
   - IF/ID gets if_id_pc = 0xFFFF_FFFC, if_id_pc_plus4 = 0x0.
   - imem_address = 0 afterwards.
6. Async reset mid-stream: drop rst_n between edges while if_id_valid = 1.
   - Immediately: if_id_valid = 0, imem_address = RESET_PC[31:2], fetch_count = 0, with no clock edge.

Source files
------------

// File: rtl/risc_pkg.sv
// Shared definitions for the RISC pipeline: datapath width, bubble encoding
// and the IF/ID pipeline register payload.
package risc_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
  } if_id_t;

endpackage

// File: rtl/risc_if_id_reg.sv
// IF/ID pipeline register: flush beats load beats hold. A flush only turns the
// slot into a bubble; the pc fields keep their last contents.
module risc_if_id_reg
  import risc_pkg::*;
#(
  parameter logic [XLEN-1:0] FLUSH_INSTR = NOP_INSTR
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   load_i,
  input  logic   flush_i,
  input  if_id_t d_i,
  output if_id_t q_o
);

  if_id_t slot_q, slot_d;

  always_comb begin
    slot_d = slot_q;
    if (flush_i) begin
      slot_d.valid = 1'b0;
      slot_d.instr = FLUSH_INSTR;
    end else if (load_i) begin
      slot_d = d_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q.valid    <= 1'b0;
      slot_q.instr    <= FLUSH_INSTR;
      slot_q.pc       <= '0;
      slot_q.pc_plus4 <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign q_o = slot_q;

endmodule

// File: rtl/risc_fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses the combinational imem and
// fills IF/ID, with redirect taking priority over advance over hold.
module risc_fetch_unit
  import risc_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [XLEN-1:0] NOP_INSTR = risc_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [29:0]     imem_address,
  input  logic [XLEN-1:0] imem_data,
  input  logic            id_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_id_valid,
  output logic [XLEN-1:0] if_id_instr,
  output logic [XLEN-1:0] if_id_pc,
  output logic [XLEN-1:0] if_id_pc_plus4,
  output logic            misalign_err,
  output logic [XLEN-1:0] fetch_count
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] fetch_count_q, fetch_count_d;
  logic            misalign_q, misalign_d;
  logic            advance;
  logic            load;
  if_id_t          if_id_d, if_id_q;

  assign pc_plus4 = pc_q + 32'd4;
  // An empty slot always fills, so bubbles never stall the front end.
  assign advance  = !if_id_q.valid || id_ready;
  assign load     = advance && !redirect_valid;

  always_comb begin
    pc_d          = pc_q;
    fetch_count_d = fetch_count_q;
    misalign_d    = 1'b0;
    if (redirect_valid) begin
      pc_d       = {redirect_pc[XLEN-1:2], 2'b00};
      misalign_d = |redirect_pc[1:0];
    end else if (advance) begin
      pc_d          = pc_plus4;
      fetch_count_d = fetch_count_q + 32'd1;
    end
  end

  always_comb begin
    if_id_d.valid    = 1'b1;
    if_id_d.instr    = imem_data;
    if_id_d.pc       = pc_q;
    if_id_d.pc_plus4 = pc_plus4;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= {RESET_PC[XLEN-1:2], 2'b00};
      fetch_count_q <= '0;
      misalign_q    <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      fetch_count_q <= fetch_count_d;
      misalign_q    <= misalign_d;
    end
  end

  risc_if_id_reg #(
    .FLUSH_INSTR(NOP_INSTR)
  ) u_if_id (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (load),
    .flush_i(redirect_valid),
    .d_i    (if_id_d),
    .q_o    (if_id_q)
  );

  assign imem_address   = pc_q[XLEN-1:2];
  assign if_id_valid    = if_id_q.valid;
  assign if_id_instr    = if_id_q.instr;
  assign if_id_pc       = if_id_q.pc;
  assign if_id_pc_plus4 = if_id_q.pc_plus4;
  assign misalign_err   = misalign_q;
  assign fetch_count    = fetch_count_q;

endmodule

// File: tb/tb_risc_fetch_unit.sv
// Bench for risc_fetch_unit: directed scenarios plus random traffic, with a
// transaction-level reference model feeding a per-cycle scoreboard.
module tb_risc_fetch_unit;
  import risc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [29:0] imem_address;
  logic [31:0] imem_data;
  logic        id_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc_plus4;
  logic        misalign_err;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  risc_fetch_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_address  (imem_address),
    .imem_data     (imem_data),
    .id_ready      (id_ready),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .if_id_valid   (if_id_valid),
    .if_id_instr   (if_id_instr),
    .if_id_pc      (if_id_pc),
    .if_id_pc_plus4(if_id_pc_plus4),
    .misalign_err  (misalign_err),
    .fetch_count   (fetch_count)
  );

  // Instruction memory contents as a pure function of byte address.
  function automatic logic [31:0] imem_fn(input logic [31:0] byte_addr);
    if (byte_addr == 32'h0) return 32'h0080_0093;
    return (byte_addr * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  assign imem_data = imem_fn({imem_address, 2'b00});

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] count;
    logic        mis;
    logic [29:0] addr;
  } exp_t;

  exp_t exp_q[$];

  function automatic exp_t reset_rec();
    exp_t r;
    r.valid = 1'b0;
    r.instr = 32'h0000_0013;
    r.pc    = 32'h0;
    r.pc4   = 32'h0;
    r.count = 32'h0;
    r.mis   = 1'b0;
    r.addr  = 30'h0;
    return r;
  endfunction

  // Reference model: what the fetch stage should hold after each edge.
  logic [31:0] m_pc;
  exp_t        m;

  always @(posedge clk) begin
    if (!rst_n) begin
      m    = reset_rec();
      m_pc = 32'h0;
    end else begin
      if (redirect_valid) begin
        m_pc    = redirect_pc & ~32'h3;
        m.valid = 1'b0;
        m.instr = 32'h0000_0013;
        m.mis   = (redirect_pc % 4) != 0;
      end else if (!m.valid || id_ready) begin
        m.instr = imem_fn(m_pc);
        m.pc    = m_pc;
        m.pc4   = m_pc + 4;
        m.valid = 1'b1;
        m.count = m.count + 1;
        m.mis   = 1'b0;
        m_pc    = m_pc + 4;
      end else begin
        m.mis = 1'b0;
      end
      m.addr = m_pc[31:2];
      exp_q.push_back(m);
    end
  end

  // Monitor: compares DUT state mid-cycle against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      exp_q.delete();
      e = reset_rec();
    end else if (exp_q.size() == 0) begin
      e = reset_rec();
    end else begin
      e = exp_q.pop_front();
    end
    chk("sb_valid",    {31'h0, if_id_valid},  {31'h0, e.valid});
    chk("sb_instr",    if_id_instr,           e.instr);
    chk("sb_pc",       if_id_pc,              e.pc);
    chk("sb_pc_plus4", if_id_pc_plus4,        e.pc4);
    chk("sb_count",    fetch_count,           e.count);
    chk("sb_misalign", {31'h0, misalign_err}, {31'h0, e.mis});
    chk("sb_imem_addr", {2'b00, imem_address}, {2'b00, e.addr});
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n          = 1'b0;
    id_ready       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    repeat (3) step();
    rst_n = 1'b1;

    // Straight-line fetch
    step();
    chk("first_valid", {31'h0, if_id_valid}, 32'h1);
    chk("first_pc",    if_id_pc,       32'h0);
    chk("first_instr", if_id_instr,    32'h0080_0093);
    chk("first_pc4",   if_id_pc_plus4, 32'h4);
    step();
    step();
    chk("count_after3", fetch_count, 32'd3);
    chk("addr_after3",  {2'b00, imem_address}, 32'd3);

    // Decode stall
    id_ready = 1'b0;
    repeat (3) step();
    chk("stall_pc",    if_id_pc, 32'h8);
    chk("stall_addr",  {2'b00, imem_address}, 32'd3);
    chk("stall_count", fetch_count, 32'd3);
    id_ready = 1'b1;
    step();
    chk("unstall_pc", if_id_pc, 32'hC);

    // Redirect while decode is stalled
    id_ready       = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    step();
    redirect_valid = 1'b0;
    chk("flush_valid", {31'h0, if_id_valid}, 32'h0);
    chk("flush_instr", if_id_instr, 32'h0000_0013);
    chk("flush_addr",  {2'b00, imem_address}, 32'h10);
    step();
    chk("target_pc",    if_id_pc, 32'h40);
    chk("target_valid", {31'h0, if_id_valid}, 32'h1);

    // Misaligned redirect
    redirect_valid = 1'b1;
    redirect_pc    = 32'h42;
    step();
    redirect_valid = 1'b0;
    chk("mis_pulse", {31'h0, misalign_err}, 32'h1);
    chk("mis_addr",  {2'b00, imem_address}, 32'h10);
    step();
    chk("mis_clear", {31'h0, misalign_err}, 32'h0);

    // PC wrap at the top of the address space
    id_ready       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    step();
    chk("wrap_pc",   if_id_pc,       32'hFFFF_FFFC);
    chk("wrap_pc4",  if_id_pc_plus4, 32'h0);
    chk("wrap_addr", {2'b00, imem_address}, 32'h0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      id_ready       = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 3))
        0:       redirect_pc = $urandom;
        1:       redirect_pc = 32'hFFFF_FFF0 + $urandom_range(0, 15);
        default: redirect_pc = $urandom_range(0, 1023);
      endcase
      step();
    end

    // Asynchronous reset between edges
    id_ready       = 1'b1;
    redirect_valid = 1'b0;
    step();
    step();
    chk("pre_reset_valid", {31'h0, if_id_valid}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("async_valid", {31'h0, if_id_valid}, 32'h0);
    chk("async_addr",  {2'b00, imem_address}, 32'h0);
    chk("async_count", fetch_count, 32'h0);
    chk("async_instr", if_id_instr, 32'h0000_0013);
    chk("async_mis",   {31'h0, misalign_err}, 32'h0);
    repeat (2) step();
    rst_n = 1'b1;

    for (int i = 0; i < 300; i++) begin
      id_ready       = ($urandom_range(0, 1) != 0);
      redirect_valid = ($urandom_range(0, 7) == 0);
      redirect_pc    = $urandom;
      step();
    end

    redirect_valid = 1'b0;
    step();
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
